// File: rtl/spram_arb_pkg.sv
// Shared types and default sizes for the single-port RAM arbiter.
// Holds the ownership state encoding used by spram_arbiter.
package spram_arb_pkg;

    localparam int AW_DEF = 12;
    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

endpackage

// File: rtl/spram_arbiter.sv
// Two-requester arbiter in front of one single-port RAM (1-cycle read).
// Define SPRAM_ARB_RR_EN for round-robin ties; otherwise port0 wins ties.
module spram_arbiter
    import spram_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          rq0_valid,
    output logic          rq0_ready,
    input  logic          rq0_we,
    input  logic [AW-1:0] rq0_addr,
    input  logic [DW-1:0] rq0_wdata,
    input  logic          rq0_lock,
    output logic          rq0_rvalid,
    output logic [DW-1:0] rq0_rdata,

    input  logic          rq1_valid,
    output logic          rq1_ready,
    input  logic          rq1_we,
    input  logic [AW-1:0] rq1_addr,
    input  logic [DW-1:0] rq1_wdata,
    input  logic          rq1_lock,
    output logic          rq1_rvalid,
    output logic [DW-1:0] rq1_rdata,

    output logic          ram_ce,
    output logic          ram_oce,
    output logic          ram_wre,
    output logic [AW-1:0] ram_ad,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    state_t        state;
    state_t        state_nx;
    logic          grant0;
    logic          grant1;
    logic          acc0;
    logic          acc1;
    logic          tie_pick1;
    logic          pend0;
    logic          pend1;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;

`ifdef SPRAM_ARB_RR_EN
    logic pref1;

    // Preference flips after every accepted transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            pref1 <= 1'b0;
        end else if (acc0 || acc1) begin
            pref1 <= ~pref1;
        end
    end

    assign tie_pick1 = pref1;
`else
    assign tie_pick1 = 1'b0;
`endif

    // Grant selection; nothing is granted while reset is high.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            unique case (state)
                IDLE: begin
                    if (rq0_valid && (!rq1_valid || !tie_pick1)) begin
                        grant0 = 1'b1;
                    end else if (rq1_valid) begin
                        grant1 = 1'b1;
                    end
                end
                OWN0:    grant0 = 1'b1;
                OWN1:    grant1 = 1'b1;
                default: ;
            endcase
        end
    end

    assign rq0_ready = grant0;
    assign rq1_ready = grant1;
    assign acc0      = rq0_valid && grant0;
    assign acc1      = rq1_valid && grant1;

    assign ram_ce  = acc0 || acc1;
    assign ram_oce = 1'b1;
    assign ram_wre = (acc0 && rq0_we) || (acc1 && rq1_we);
    assign ram_ad  = grant1 ? rq1_addr : rq0_addr;
    assign ram_din = grant1 ? rq1_wdata : rq0_wdata;

    // Ownership: a locked accept keeps the grant on that port.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (acc0 && rq0_lock) begin
                    state_nx = OWN0;
                end else if (acc1 && rq1_lock) begin
                    state_nx = OWN1;
                end
            end
            OWN0: begin
                if (!rq0_lock && (acc0 || !rq0_valid)) begin
                    state_nx = IDLE;
                end
            end
            OWN1: begin
                if (!rq1_lock && (acc1 || !rq1_valid)) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Remember which port owns the read data arriving next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend0 <= 1'b0;
            pend1 <= 1'b0;
        end else begin
            pend0 <= acc0 && !rq0_we;
            pend1 <= acc1 && !rq1_we;
        end
    end

    // A read pending across reset is dropped combinationally.
    assign rq0_rvalid = pend0 && !reset;
    assign rq1_rvalid = pend1 && !reset;

    // Capture returned data so it holds while rvalid is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (rq0_rvalid) begin
                rdata0_q <= ram_dout;
            end
            if (rq1_rvalid) begin
                rdata1_q <= ram_dout;
            end
        end
    end

    assign rq0_rdata = rq0_rvalid ? ram_dout : rdata0_q;
    assign rq1_rdata = rq1_rvalid ? ram_dout : rdata1_q;

    rq0_hold: assert property (@(posedge clk) disable iff (reset)
        (rq0_valid && !rq0_ready) |=> (!rq0_valid ||
        $stable({rq0_we, rq0_addr, rq0_wdata, rq0_lock})));

    rq1_hold: assert property (@(posedge clk) disable iff (reset)
        (rq1_valid && !rq1_ready) |=> (!rq1_valid ||
        $stable({rq1_we, rq1_addr, rq1_wdata, rq1_lock})));

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed vector bench for spram_arbiter with a behavioural RAM.
// Expectations follow the build: SPRAM_ARB_RR_EN selects round-robin ties.
module tb_spram_arbiter;

    logic        clk;
    logic        reset;
    logic        rq0_valid, rq0_ready, rq0_we, rq0_lock, rq0_rvalid;
    logic [11:0] rq0_addr;
    logic [7:0]  rq0_wdata, rq0_rdata;
    logic        rq1_valid, rq1_ready, rq1_we, rq1_lock, rq1_rvalid;
    logic [11:0] rq1_addr;
    logic [7:0]  rq1_wdata, rq1_rdata;
    logic        ram_ce, ram_oce, ram_wre;
    logic [11:0] ram_ad;
    logic [7:0]  ram_din, ram_dout;

    int checks;
    int failures;

    spram_arbiter #(.AW(12), .DW(8)) dut (
        .clk(clk), .reset(reset),
        .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_we(rq0_we),
        .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata), .rq0_lock(rq0_lock),
        .rq0_rvalid(rq0_rvalid), .rq0_rdata(rq0_rdata),
        .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_we(rq1_we),
        .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata), .rq1_lock(rq1_lock),
        .rq1_rvalid(rq1_rvalid), .rq1_rdata(rq1_rdata),
        .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_wre(ram_wre),
        .ram_ad(ram_ad), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM, registered output, write-through, sync reset.
    logic [7:0] mem [0:4095];
    always @(posedge clk) begin
        if (reset) begin
            ram_dout <= 8'h00;
        end else if (ram_ce) begin
            if (ram_wre) begin
                mem[ram_ad] <= ram_din;
                ram_dout    <= ram_din;
            end else begin
                ram_dout <= mem[ram_ad];
            end
        end
    end

    typedef struct packed {
        logic        v;
        logic        we;
        logic [11:0] a;
        logic [7:0]  d;
        logic        l;
    } port_t;

    typedef struct packed {
        logic        r0;
        logic        r1;
        logic        ce;
        logic        wre;
        logic [11:0] ad;
        logic        rv0;
        logic        rv1;
        logic [7:0]  rd0;
        logic [7:0]  rd1;
        logic        ckrd;
    } exp_t;

    typedef struct {
        logic  rst;
        port_t p0;
        port_t p1;
        exp_t  e;
    } vec_t;

    localparam int NV = 31;
    vec_t tv [NV];

    function automatic port_t idl();
        return '0;
    endfunction

    function automatic port_t rd(logic [11:0] a);
        port_t p;
        p = '0;
        p.v = 1'b1;
        p.a = a;
        return p;
    endfunction

    function automatic port_t rdl(logic [11:0] a);
        port_t p;
        p = rd(a);
        p.l = 1'b1;
        return p;
    endfunction

    function automatic port_t wr(logic [11:0] a, logic [7:0] d,
                                 logic l);
        port_t p;
        p = '0;
        p.v  = 1'b1;
        p.we = 1'b1;
        p.a  = a;
        p.d  = d;
        p.l  = l;
        return p;
    endfunction

    function automatic exp_t ex(logic r0, logic r1, logic ce,
                                logic wre, logic [11:0] ad,
                                logic rv0, logic rv1,
                                logic [7:0] rd0, logic [7:0] rd1);
        exp_t e;
        e.r0   = r0;
        e.r1   = r1;
        e.ce   = ce;
        e.wre  = wre;
        e.ad   = ad;
        e.rv0  = rv0;
        e.rv1  = rv1;
        e.rd0  = rd0;
        e.rd1  = rd1;
        e.ckrd = 1'b1;
        return e;
    endfunction

    function automatic vec_t mk(logic rst, port_t p0, port_t p1,
                                exp_t e);
        vec_t v;
        v.rst = rst;
        v.p0  = p0;
        v.p1  = p1;
        v.e   = e;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drive(logic rst, port_t p0, port_t p1);
        reset     = rst;
        rq0_valid = p0.v;
        rq0_we    = p0.we;
        rq0_addr  = p0.a;
        rq0_wdata = p0.d;
        rq0_lock  = p0.l;
        rq1_valid = p1.v;
        rq1_we    = p1.we;
        rq1_addr  = p1.a;
        rq1_wdata = p1.d;
        rq1_lock  = p1.l;
    endtask

    task automatic check_vec(int i, exp_t e);
        chk($sformatf("v%0d_ready0", i), 32'(rq0_ready), 32'(e.r0));
        chk($sformatf("v%0d_ready1", i), 32'(rq1_ready), 32'(e.r1));
        chk($sformatf("v%0d_ce", i), 32'(ram_ce), 32'(e.ce));
        chk($sformatf("v%0d_wre", i), 32'(ram_wre), 32'(e.wre));
        if (e.ce) begin
            chk($sformatf("v%0d_ad", i), 32'(ram_ad), 32'(e.ad));
        end
        chk($sformatf("v%0d_rvalid0", i), 32'(rq0_rvalid), 32'(e.rv0));
        chk($sformatf("v%0d_rvalid1", i), 32'(rq1_rvalid), 32'(e.rv1));
        if (e.ckrd) begin
            chk($sformatf("v%0d_rdata0", i), 32'(rq0_rdata), 32'(e.rd0));
            chk($sformatf("v%0d_rdata1", i), 32'(rq1_rdata), 32'(e.rd1));
        end
    endtask

    initial begin
        exp_t  e0;
        port_t p0lk;
        int    n;

        checks   = 0;
        failures = 0;
        for (int k = 0; k < 4096; k++) mem[k] = 8'h00;
        mem[12'h010] = 8'hA5;
        mem[12'h020] = 8'h11;
        mem[12'h021] = 8'h22;
        mem[12'h030] = 8'h33;
        drive(1'b1, idl(), idl());

        p0lk   = '0;
        p0lk.l = 1'b1;
        e0      = ex(0, 0, 0, 0, 12'h000, 0, 0, 8'h00, 8'h00);
        e0.ckrd = 1'b0;

        // reset, first accept after release, held rdata
        tv[0]  = mk(1, rd(12'h010), idl(), e0);
        tv[1]  = mk(1, idl(), idl(),
                    ex(0, 0, 0, 0, 12'h000, 0, 0, 8'h00, 8'h00));
        tv[2]  = mk(0, rd(12'h010), idl(),
                    ex(1, 0, 1, 0, 12'h010, 0, 0, 8'h00, 8'h00));
        tv[3]  = mk(0, idl(), idl(),
                    ex(0, 0, 0, 0, 12'h000, 1, 0, 8'hA5, 8'h00));
        tv[4]  = mk(0, idl(), idl(),
                    ex(0, 0, 0, 0, 12'h000, 0, 0, 8'hA5, 8'h00));
        // write then read at top address
        tv[5]  = mk(0, wr(12'hFFF, 8'h3C, 0), idl(),
                    ex(1, 0, 1, 1, 12'hFFF, 0, 0, 8'hA5, 8'h00));
        tv[6]  = mk(0, idl(), rd(12'hFFF),
                    ex(0, 1, 1, 0, 12'hFFF, 0, 0, 8'hA5, 8'h00));
        tv[7]  = mk(0, idl(), idl(),
                    ex(0, 0, 0, 0, 12'h000, 0, 1, 8'hA5, 8'h3C));
        // back-to-back alternating reads
        tv[8]  = mk(0, rd(12'h020), idl(),
                    ex(1, 0, 1, 0, 12'h020, 0, 0, 8'hA5, 8'h3C));
        tv[9]  = mk(0, idl(), rd(12'h021),
                    ex(0, 1, 1, 0, 12'h021, 1, 0, 8'h11, 8'h3C));
        tv[10] = mk(0, rd(12'h030), idl(),
                    ex(1, 0, 1, 0, 12'h030, 0, 1, 8'h11, 8'h22));
        tv[11] = mk(0, idl(), idl(),
                    ex(0, 0, 0, 0, 12'h000, 1, 0, 8'h33, 8'h22));
        // locked write burst from rq1 with rq0 waiting
        tv[12] = mk(0, idl(), wr(12'h100, 8'hB0, 1),
                    ex(0, 1, 1, 1, 12'h100, 0, 0, 8'h33, 8'h22));
        tv[13] = mk(0, rd(12'h010), wr(12'h101, 8'hB1, 1),
                    ex(0, 1, 1, 1, 12'h101, 0, 0, 8'h33, 8'h22));
        tv[14] = mk(0, rd(12'h010), wr(12'h102, 8'hB2, 1),
                    ex(0, 1, 1, 1, 12'h102, 0, 0, 8'h33, 8'h22));
        tv[15] = mk(0, rd(12'h010), wr(12'h103, 8'hB3, 0),
                    ex(0, 1, 1, 1, 12'h103, 0, 0, 8'h33, 8'h22));
        tv[16] = mk(0, rd(12'h010), idl(),
                    ex(1, 0, 1, 0, 12'h010, 0, 0, 8'h33, 8'h22));
        tv[17] = mk(0, idl(), idl(),
                    ex(0, 0, 0, 0, 12'h000, 1, 0, 8'hA5, 8'h22));
        // lock held across an idle gap
        tv[18] = mk(0, rdl(12'h100), idl(),
                    ex(1, 0, 1, 0, 12'h100, 0, 0, 8'hA5, 8'h22));
        tv[19] = mk(0, p0lk, rd(12'h103),
                    ex(1, 0, 0, 0, 12'h000, 1, 0, 8'hB0, 8'h22));
        tv[20] = mk(0, idl(), rd(12'h103),
                    ex(1, 0, 0, 0, 12'h000, 0, 0, 8'hB0, 8'h22));
        tv[21] = mk(0, idl(), rd(12'h103),
                    ex(0, 1, 1, 0, 12'h103, 0, 0, 8'hB0, 8'h22));
        tv[22] = mk(0, idl(), idl(),
                    ex(0, 0, 0, 0, 12'h000, 0, 1, 8'hB0, 8'hB3));
        // reset lands on a pending read
        tv[23] = mk(0, rd(12'h010), idl(),
                    ex(1, 0, 1, 0, 12'h010, 0, 0, 8'hB0, 8'hB3));
        tv[24] = mk(1, idl(), idl(),
                    ex(0, 0, 0, 0, 12'h000, 0, 0, 8'hB0, 8'hB3));
        tv[25] = mk(0, rd(12'h020), rd(12'h021),
                    ex(1, 0, 1, 0, 12'h020, 0, 0, 8'h00, 8'h00));
        // continuous tie
`ifdef SPRAM_ARB_RR_EN
        tv[26] = mk(0, rd(12'h030), rd(12'h021),
                    ex(0, 1, 1, 0, 12'h021, 1, 0, 8'h11, 8'h00));
        tv[27] = mk(0, rd(12'h030), rd(12'h021),
                    ex(1, 0, 1, 0, 12'h030, 0, 1, 8'h11, 8'h22));
        tv[28] = mk(0, rd(12'h030), rd(12'h021),
                    ex(0, 1, 1, 0, 12'h021, 1, 0, 8'h33, 8'h22));
        tv[29] = mk(0, idl(), idl(),
                    ex(0, 0, 0, 0, 12'h000, 0, 1, 8'h33, 8'h22));
        tv[30] = mk(0, idl(), idl(),
                    ex(0, 0, 0, 0, 12'h000, 0, 0, 8'h33, 8'h22));
`else
        tv[26] = mk(0, rd(12'h030), rd(12'h021),
                    ex(1, 0, 1, 0, 12'h030, 1, 0, 8'h11, 8'h00));
        tv[27] = mk(0, rd(12'h030), rd(12'h021),
                    ex(1, 0, 1, 0, 12'h030, 1, 0, 8'h33, 8'h00));
        tv[28] = mk(0, rd(12'h030), rd(12'h021),
                    ex(1, 0, 1, 0, 12'h030, 1, 0, 8'h33, 8'h00));
        tv[29] = mk(0, idl(), idl(),
                    ex(0, 0, 0, 0, 12'h000, 1, 0, 8'h33, 8'h00));
        tv[30] = mk(0, idl(), idl(),
                    ex(0, 0, 0, 0, 12'h000, 0, 0, 8'h33, 8'h00));
`endif

        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            drive(tv[i].rst, tv[i].p0, tv[i].p1);
            #4;
            check_vec(i, tv[i].e);
        end

        // RAM memory must hold the write-through data
        chk("mem_fff", 32'(mem[12'hFFF]), 32'h3C);
        chk("mem_102", 32'(mem[12'h102]), 32'hB2);
        chk("oce_const", 32'(ram_oce), 32'h1);

        // bounded wait for an rq1 read return
        @(posedge clk);
        #1;
        drive(1'b0, idl(), rd(12'h010));
        #4;
        chk("seq_ready1", 32'(rq1_ready), 32'h1);
        @(posedge clk);
        #1;
        drive(1'b0, idl(), idl());
        n = 0;
        while (!rq1_rvalid && n < 4) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("seq_latency", 32'(n), 32'h0);
        chk("seq_rdata1", 32'(rq1_rdata), 32'hA5);
        chk("seq_rvalid0", 32'(rq0_rvalid), 32'h0);
        @(posedge clk);
        #1;
        chk("seq_rvalid1_off", 32'(rq1_rvalid), 32'h0);
        chk("seq_rdata1_hold", 32'(rq1_rdata), 32'hA5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
